// File: rtl/vga_pkg.sv
// Shared definitions for the VGA drawing blocks.
//   SCREEN_W / SCREEN_H : visible screen size in pixels
//   colour_t            : 3-bit pixel colour
//   coord_t             : 8-bit screen coordinate
//   plot_state_t        : sprite plotter FSM state
//   cnt_w()             : width of a counter that spans 0..n-1 (at least 1 bit)
//   coord_add()         : 9-bit anchor + offset, so there is no 8-bit wrap-around
package vga_pkg;

   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;

   typedef logic [2:0] colour_t;
   typedef logic [7:0] coord_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ERASE = 2'd1,
      ST_DRAW  = 2'd2,
      ST_FIN   = 2'd3
   } plot_state_t;

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [8:0] coord_add(input coord_t base, input logic [7:0] off);
      return {1'b0, base} + {1'b0, off};
   endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major offset counter for walking a sprite footprint.
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : force both offsets to 0 (wins over en_i)
//   en_i       : advance one pixel; ox first, wrapping into oy
//   ox_o, oy_o : current x / y offset
//   last_o     : current offset is the final pixel (SPRITE_W-1, SPRITE_H-1)
module sprite_scan_counter
   import vga_pkg::*;
#(
   parameter int unsigned SPRITE_W = 2,
   parameter int unsigned SPRITE_H = 4,
   localparam int unsigned OX_W = cnt_w(SPRITE_W),
   localparam int unsigned OY_W = cnt_w(SPRITE_H)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr_i,
   input  logic            en_i,
   output logic [OX_W-1:0] ox_o,
   output logic [OY_W-1:0] oy_o,
   output logic            last_o
);

   localparam logic [OX_W-1:0] OX_LAST = OX_W'(SPRITE_W - 1);
   localparam logic [OY_W-1:0] OY_LAST = OY_W'(SPRITE_H - 1);

   logic [OX_W-1:0] ox_q, ox_d;
   logic [OY_W-1:0] oy_q, oy_d;

   always_comb begin
      ox_d = ox_q;
      oy_d = oy_q;
      if (clr_i) begin
         ox_d = '0;
         oy_d = '0;
      end else if (en_i) begin
         if (ox_q == OX_LAST) begin
            ox_d = '0;
            oy_d = (oy_q == OY_LAST) ? '0 : oy_q + OY_W'(1);
         end else begin
            ox_d = ox_q + OX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ox_q <= '0;
         oy_q <= '0;
      end else begin
         ox_q <= ox_d;
         oy_q <= oy_d;
      end
   end

   assign ox_o   = ox_q;
   assign oy_o   = oy_q;
   assign last_o = (ox_q == OX_LAST) && (oy_q == OY_LAST);

endmodule

// File: rtl/sprite_plotter.sv
// Sprite plotter: accepts a sprite anchor and colour over valid/ready, erases the previous
// footprint in BG_COLOUR, then draws the new footprint, one pixel per cycle to the VGA adapter.
//   clk, reset          : clock, asynchronous active-high reset
//   pos_valid/pos_ready : anchor handshake; ready only while idle
//   pos_x, pos_y        : anchor column / row
//   pos_colour          : sprite colour
//   vga_x, vga_y        : registered pixel coordinate (low 8 bits of the 9-bit sum)
//   vga_colour          : registered pixel colour
//   vga_plot            : registered write strobe, low for off-screen or masked slots
//   busy                : high while erasing or drawing
//   done                : one-cycle pulse the cycle after the last draw pixel appears
// Build option: define SPRITE_PLOTTER_MASK_EN to gate plotting with a constant sprite mask
// (bit index oy*SPRITE_W+ox). Timing is identical with or without it.
module sprite_plotter
   import vga_pkg::*;
#(
   parameter int unsigned SPRITE_W  = 2,
   parameter int unsigned SPRITE_H  = 4,
   parameter int unsigned SCREEN_W  = vga_pkg::SCREEN_W,
   parameter int unsigned SCREEN_H  = vga_pkg::SCREEN_H,
   parameter colour_t     BG_COLOUR = 3'b000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pos_valid,
   output logic       pos_ready,
   input  logic [7:0] pos_x,
   input  logic [7:0] pos_y,
   input  logic [2:0] pos_colour,
   output logic [7:0] vga_x,
   output logic [7:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic       done
);

   localparam int unsigned OX_W = cnt_w(SPRITE_W);
   localparam int unsigned OY_W = cnt_w(SPRITE_H);
   localparam logic [8:0]  SCREEN_W9 = 9'(SCREEN_W);
   localparam logic [8:0]  SCREEN_H9 = 9'(SCREEN_H);

`ifdef SPRITE_PLOTTER_MASK_EN
   localparam int unsigned NPIX = SPRITE_W * SPRITE_H;
   localparam logic [NPIX-1:0] SPRITE_MASK = NPIX'(8'b10100101);
`endif

   plot_state_t state_q, state_d;
   logic        has_prev_q, has_prev_d;
   coord_t      new_x_q, new_x_d;
   coord_t      new_y_q, new_y_d;
   colour_t     new_colour_q, new_colour_d;
   coord_t      prev_x_q, prev_x_d;
   coord_t      prev_y_q, prev_y_d;

   coord_t      vga_x_q, vga_x_d;
   coord_t      vga_y_q, vga_y_d;
   colour_t     vga_colour_q, vga_colour_d;
   logic        vga_plot_q, vga_plot_d;
   logic        done_q, done_d;

   logic            cnt_clr;
   logic            cnt_en;
   logic [OX_W-1:0] ox;
   logic [OY_W-1:0] oy;
   logic            cnt_last;

   sprite_scan_counter #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H)
   ) u_scan (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .ox_o   (ox),
      .oy_o   (oy),
      .last_o (cnt_last)
   );

   // Control FSM
   always_comb begin
      state_d      = state_q;
      has_prev_d   = has_prev_q;
      new_x_d      = new_x_q;
      new_y_d      = new_y_q;
      new_colour_d = new_colour_q;
      prev_x_d     = prev_x_q;
      prev_y_d     = prev_y_q;
      cnt_clr      = 1'b0;
      cnt_en       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (pos_valid) begin
               new_x_d      = pos_x;
               new_y_d      = pos_y;
               new_colour_d = pos_colour;
               state_d      = has_prev_q ? ST_ERASE : ST_DRAW;
            end
         end
         ST_ERASE: begin
            if (cnt_last) begin
               cnt_clr = 1'b1;
               state_d = ST_DRAW;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_DRAW: begin
            if (cnt_last) begin
               cnt_clr = 1'b1;
               state_d = ST_FIN;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_FIN: begin
            prev_x_d   = new_x_q;
            prev_y_d   = new_y_q;
            has_prev_d = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pixel generation; registered so each slot appears the cycle after its counter value.
   logic       scanning;
   logic       erasing;
   coord_t     base_x;
   coord_t     base_y;
   logic [8:0] x9;
   logic [8:0] y9;
   logic       in_screen;
   logic       mask_on;

   always_comb begin
      erasing   = (state_q == ST_ERASE);
      scanning  = erasing || (state_q == ST_DRAW);
      base_x    = erasing ? prev_x_q : new_x_q;
      base_y    = erasing ? prev_y_q : new_y_q;
      x9        = coord_add(base_x, 8'(ox));
      y9        = coord_add(base_y, 8'(oy));
      in_screen = (x9 < SCREEN_W9) && (y9 < SCREEN_H9);
   end

`ifdef SPRITE_PLOTTER_MASK_EN
   logic [31:0]     pix_idx;
   logic [NPIX-1:0] mask_vec;

   always_comb begin
      pix_idx  = 32'(oy) * SPRITE_W + 32'(ox);
      mask_vec = SPRITE_MASK >> pix_idx;
      mask_on  = mask_vec[0];
   end
`else
   assign mask_on = 1'b1;
`endif

   always_comb begin
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      vga_plot_d   = scanning && in_screen && mask_on;
      done_d       = (state_q == ST_FIN);
      if (scanning) begin
         vga_x_d      = x9[7:0];
         vga_y_d      = y9[7:0];
         vga_colour_d = erasing ? BG_COLOUR : new_colour_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         has_prev_q   <= 1'b0;
         new_x_q      <= '0;
         new_y_q      <= '0;
         new_colour_q <= '0;
         prev_x_q     <= '0;
         prev_y_q     <= '0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         has_prev_q   <= has_prev_d;
         new_x_q      <= new_x_d;
         new_y_q      <= new_y_d;
         new_colour_q <= new_colour_d;
         prev_x_q     <= prev_x_d;
         prev_y_q     <= prev_y_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
         done_q       <= done_d;
      end
   end

   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;
   assign done       = done_q;
   assign busy       = (state_q == ST_ERASE) || (state_q == ST_DRAW);
   assign pos_ready  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: directed scenarios plus random anchors, checked
// slot-by-slot against a footprint list built from the sprite rules.
module tb_sprite_plotter;

   localparam int W = 2;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       pos_valid;
   logic       pos_ready;
   logic [7:0] pos_x;
   logic [7:0] pos_y;
   logic [2:0] pos_colour;
   logic [7:0] vga_x;
   logic [7:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit          m_has_prev;
   int          m_px;
   int          m_py;
   logic [19:0] exp_q[$];  // {plot, x, y, colour} per slot

   sprite_plotter dut (
      .clk        (clk),
      .reset      (reset),
      .pos_valid  (pos_valid),
      .pos_ready  (pos_ready),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .pos_colour (pos_colour),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit mask_bit(input int idx);
`ifdef SPRITE_PLOTTER_MASK_EN
      bit [7:0] m = 8'b10100101;
`else
      bit [7:0] m = 8'hFF;
`endif
      return ((m >> idx) & 8'h01) != 8'h00;
   endfunction

   function automatic void add_pass(input int ax, input int ay, input logic [2:0] c);
      for (int oy = 0; oy < H; oy++) begin
         for (int ox = 0; ox < W; ox++) begin
            int         px = ax + ox;
            int         py = ay + oy;
            bit         p  = (px < 160) && (py < 120) && mask_bit(oy * W + ox);
            logic [7:0] lx = px[7:0];
            logic [7:0] ly = py[7:0];
            exp_q.push_back({p, lx, ly, c});
         end
      end
   endfunction

   // Present a request at the current negedge and follow it to done. With hold_next, the next
   // request's data is presented right after acceptance and held while busy. abort_at >= 0
   // asserts reset in that slot cycle and returns.
   task automatic run_req(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c,
                          input bit hold_next, input logic [7:0] nx, input logic [7:0] ny,
                          input logic [2:0] nc, input int abort_at);
      int wait_n = 0;
      pos_valid  = 1'b1;
      pos_x      = x;
      pos_y      = y;
      pos_colour = c;
      while (pos_ready !== 1'b1 && wait_n < 100) begin
         @(negedge clk);
         wait_n++;
      end
      if (pos_ready !== 1'b1) begin
         check_eq("accept_timeout", 32'(pos_ready), 32'd1);
         pos_valid = 1'b0;
         return;
      end
      exp_q.delete();
      if (m_has_prev) add_pass(m_px, m_py, 3'b000);
      add_pass(int'(x), int'(y), c);
      @(negedge clk);
      if (hold_next) begin
         pos_x      = nx;
         pos_y      = ny;
         pos_colour = nc;
      end else begin
         pos_valid = 1'b0;
      end
      check_eq("lat_busy", 32'(busy), 32'd1);
      check_eq("lat_plot", 32'(vga_plot), 32'd0);
      check_eq("lat_ready", 32'(pos_ready), 32'd0);
      for (int s = 0; s < exp_q.size(); s++) begin
         @(negedge clk);
         if (s == abort_at) begin
            reset = 1'b1;
            #1;
            check_eq("rst_plot", 32'(vga_plot), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_ready", 32'(pos_ready), 32'd1);
            check_eq("rst_done", 32'(done), 32'd0);
            @(negedge clk);
            reset      = 1'b0;
            pos_valid  = 1'b0;
            m_has_prev = 1'b0;
            return;
         end
         check_eq("slot", 32'({vga_plot, vga_x, vga_y, vga_colour}), 32'(exp_q[s]));
         check_eq("slot_ready", 32'(pos_ready), 32'd0);
         check_eq("slot_done", 32'(done), 32'd0);
      end
      @(negedge clk);
      check_eq("done", 32'(done), 32'd1);
      check_eq("done_plot", 32'(vga_plot), 32'd0);
      check_eq("done_ready", 32'(pos_ready), 32'd1);
      check_eq("done_busy", 32'(busy), 32'd0);
      m_has_prev = 1'b1;
      m_px       = int'(x);
      m_py       = int'(y);
   endtask

   function automatic logic [7:0] rand_coord(input int edge_lo);
      if ($urandom_range(0, 2) == 0) return 8'($urandom_range(edge_lo, 255));
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      logic [7:0] cx, cy, nx, ny;
      logic [2:0] cc, nc;
      bit         hold;

      reset      = 1'b1;
      pos_valid  = 1'b0;
      pos_x      = '0;
      pos_y      = '0;
      pos_colour = '0;
      m_has_prev = 1'b0;
      m_px       = 0;
      m_py       = 0;
      repeat (2) @(negedge clk);
      check_eq("reset_vga", 32'({vga_x, vga_y, vga_colour}), 32'd0);
      check_eq("reset_plot", 32'(vga_plot), 32'd0);
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_done", 32'(done), 32'd0);
      check_eq("reset_ready", 32'(pos_ready), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      // First request draws only, second erases then draws.
      run_req(8'd155, 8'd110, 3'b010, 1'b0, 8'd0, 8'd0, 3'd0, -1);
      run_req(8'd156, 8'd110, 3'b100, 1'b0, 8'd0, 8'd0, 3'd0, -1);

      // Reset in the middle of the erase pass.
      run_req(8'd20, 8'd30, 3'b111, 1'b0, 8'd0, 8'd0, 3'd0, 3);

      // Clipping at the screen corner, first request after reset.
      run_req(8'd159, 8'd118, 3'b011, 1'b0, 8'd0, 8'd0, 3'd0, -1);

      // Backpressure: next request held valid while busy.
      run_req(8'd40, 8'd50, 3'b001, 1'b1, 8'd41, 8'd50, 3'b110, -1);
      run_req(8'd41, 8'd50, 3'b110, 1'b0, 8'd0, 8'd0, 3'd0, -1);
      repeat (3) begin
         @(negedge clk);
         check_eq("idle_plot", 32'(vga_plot), 32'd0);
         check_eq("idle_busy", 32'(busy), 32'd0);
      end

      // Random anchors, biased toward the clipping edges, with random back-to-back requests.
      cx = rand_coord(150);
      cy = rand_coord(110);
      cc = 3'($urandom_range(0, 7));
      for (int i = 0; i < 40; i++) begin
         hold = ($urandom_range(0, 3) == 0);
         nx   = rand_coord(150);
         ny   = rand_coord(110);
         nc   = 3'($urandom_range(0, 7));
         run_req(cx, cy, cc, hold, nx, ny, nc, -1);
         if (hold) begin
            cx = nx;
            cy = ny;
            cc = nc;
         end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            cx = rand_coord(150);
            cy = rand_coord(110);
            cc = 3'($urandom_range(0, 7));
         end
      end
      run_req(cx, cy, cc, 1'b0, 8'd0, 8'd0, 3'd0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
- Consumer side of the ship-position interface: accepts a sprite anchor (x,y) and colour from the player/game logic over a valid/ready handshake.
- Walks the sprite's pixel offsets itself, erasing the previous footprint in background colour, then drawing the new one.
- Emits one pixel per cycle to the VGA adapter as x, y, colour and plot.
- Sits between the player/enemy position generators and the VGA adapter's plot port.

Parameters:
- SPRITE_W, 2, sprite width in pixels (x offset range 0..SPRITE_W-1).
- SPRITE_H, 4, sprite height in pixels (y offset range 0..SPRITE_H-1).
- SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped.
- BG_COLOUR, 3'b000, colour used for erase pixels.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pos_valid  in  1  new anchor presented.
- pos_ready  out  1  block can accept an anchor.
- pos_x  in  8  anchor column.
- pos_y  in  8  anchor row.
- pos_colour  in  3  sprite colour.
- vga_x  out  8  pixel column to the VGA adapter.
- vga_y  out  8  pixel row to the VGA adapter.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write strobe, one pixel per high cycle.
- busy  out  1  high in ERASE or DRAW.
- done  out  1  one-cycle pulse after the last draw pixel.

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE, has_prev=0;
  - vga_x, vga_y, vga_colour all 0;
  - vga_plot=0, busy=0, done=0, pos_ready=1;
  - offset counters 0.
- FSM states: IDLE, ERASE, DRAW, FIN.
- IDLE:
  - pos_ready=1.
  - On pos_valid&&pos_ready, latch new_x/new_y/new_colour.
  - Go to ERASE if has_prev=1, else go to DRAW.
  - Offsets cleared on entry.
- ERASE:
  - One pixel per cycle at (prev_x+ox, prev_y+oy), colour BG_COLOUR.
  - Scan order is row-major: ox increments first; it wraps to 0 at SPRITE_W-1 and oy increments.
  - After the pixel ox=SPRITE_W-1, oy=SPRITE_H-1, go to DRAW with offsets cleared.
- DRAW:
  - Same scan order at (new_x+ox, new_y+oy), colour new_colour.
  - After the last pixel, go to FIN.
- FIN:
  - done=1 for exactly one cycle.
  - prev_x/prev_y <= new_x/new_y, has_prev <= 1.
  - Next state IDLE.
- Outputs are registered: vga_* for a pixel are valid in the cycle after the counter state that generates them.
  - Acceptance in cycle N gives the first vga_plot in cycle N+2.
  - Total cycles per request are 2*W*H (with prev) or W*H (first), plus FIN.
- pos_ready=0 in every state except IDLE.
  - Upstream must hold pos_valid and data stable until accepted.
  - Nothing is dropped or queued.
- Arithmetic: pixel coordinates are computed 9 bits wide (anchor + offset), so there is no 8-bit wrap-around.
- Clipping: if x9 >= SCREEN_W or y9 >= SCREEN_H, vga_plot=0 for that slot.
  - The slot still consumes its cycle, so the cycle count is unchanged.
  - vga_x/vga_y carry the low 8 bits.
- The same anchor as prev still performs a full erase+draw; this is required so colour changes take effect.
- Reset mid-ERASE/DRAW aborts immediately: vga_plot drops asynchronously and has_prev=0. Stale pixels are the game's concern; it redraws.

Optional Feature:
- Macro: SPRITE_PLOTTER_MASK_EN.
- Defined: an internal SPRITE_W*SPRITE_H-bit constant mask (bit index oy*SPRITE_W+ox) gates vga_plot in both ERASE and DRAW. Pixels with a 0 mask bit are skipped (plot=0, cycle still consumed).
- Undefined: the sprite is a solid rectangle and every in-screen slot plots.
- Timing and done position are identical either way.

Decomposition:
- Shared package vga_pkg holds:
  - SCREEN_W and SCREEN_H;
  - colour typedef (3-bit);
  - coordinate typedef (8-bit);
  - plotter state enum.
- One sub-module, sprite_scan_counter: ox/oy counter with clear, enable, last-pixel flag. It is instantiated once and reused for both passes.

Test Plan:
- First request after reset, (155,110) colour 3'b010:
  - 8 plots, in order (155,110),(156,110),(155,111)…(156,113), all colour 010;
  - no erase;
  - done one cycle after the last plot;
  - pos_ready returns to 1.
- Second request (156,110) colour 3'b100:
  - 8 erase plots at the old footprint in colour 000;
  - then 8 draw plots starting at (156,110);
  - 17 cycles from the first plot to done inclusive.
- Clipping, first request at (159,118):
  - only (159,118) and (159,119) plot;
  - 8 scan cycles total;
  - no write with x=160 or y>=120.
- Backpressure: hold pos_valid with new data while busy -> pos_ready=0 throughout, then accepted on the IDLE cycle with exactly one transaction.
- Reset asserted mid-ERASE -> vga_plot=0, busy=0, pos_ready=1 immediately; the next request draws without erase (8 plots).
- With SPRITE_PLOTTER_MASK_EN and mask 8'b10100101 -> only the 4 mask-1 offsets plot; done timing is the same as without the macro.
